// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter and the multicycle control FSM.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2
  } arb_state_e;

  typedef enum logic {
    GntI = 1'b0,
    GntD = 1'b1
  } gnt_e;

  typedef enum logic [2:0] {
    CtrlFetch  = 3'd0,
    CtrlDecode = 3'd1,
    CtrlExec   = 3'd2,
    CtrlMem    = 3'd3,
    CtrlWb     = 3'd4
  } ctrl_state_e;

  // On contention the side not granted last time wins.
  function automatic gnt_e pick_gnt(logic if_req, logic d_req, gnt_e last_gnt);
    if (if_req && (!d_req || last_gnt == GntD)) return GntI;
    return GntD;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_timeout_cnt.sv
// Wait-state counter; flags expiry on the busy cycle that would bring the count to TIMEOUT.
module arb_timeout_cnt #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          expire
);

  localparam logic [CW-1:0] LastCnt = CW'(TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == LastCnt);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and load/store.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          err
);

  arb_state_e    state;
  gnt_e          last_gnt;
  gnt_e          gnt;
  logic          busy;
  logic          cnt_clr;
  logic          cnt_en;
  logic          expire;
  logic [CW-1:0] cnt;

  assign busy    = (state != StIdle);
  assign cnt_en  = busy && !mem_ready;
  assign cnt_clr = !busy || mem_ready;
  assign gnt     = pick_gnt(if_req, d_req, last_gnt);

  arb_timeout_cnt #(
    .TIMEOUT(TIMEOUT),
    .CW     (CW)
  ) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .cnt   (cnt),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= StIdle;
      last_gnt  <= GntD;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
      case (state)
        StIdle: begin
          if (if_req || d_req) begin
            mem_en   <= 1'b1;
            last_gnt <= gnt;
            if (gnt == GntI) begin
              state    <= StBusyI;
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
            end else begin
              state     <= StBusyD;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end
          end
        end
        StBusyI, StBusyD: begin
          // Ready takes priority over a coinciding timeout.
          if (mem_ready || expire) begin
            state  <= StIdle;
            mem_en <= 1'b0;
            err    <= !mem_ready;
            if (state == StBusyI) begin
              if_done  <= 1'b1;
              if_rdata <= mem_ready ? mem_rdata : '0;
            end else begin
              d_done <= 1'b1;
              if (!mem_ready) begin
                d_rdata <= '0;
              end else if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end
        end
        default: begin
          state  <= StIdle;
          mem_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single unified memory port between the instruction-fetch requester and the load/store requester.
- Accepts a request from each side, grants one at a time, and drives the memory interface until the memory signals ready.
- Returns read data and a one-cycle done pulse to the granted side.
- Sits between the multicycle control FSM/datapath and the memory; it also bounds stalls with a timeout error.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- TIMEOUT, 15: maximum number of busy cycles without mem_ready before a transaction aborts. Must be at least 1.
- CW, 4: width of the timeout counter. Must satisfy 2^CW > TIMEOUT.

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  synchronous reset, active-low
- if_req  in  1  fetch request; held until if_done
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word; valid while if_done=1, then held
- if_done  out  1  one-cycle completion pulse to fetch side
- d_req  in  1  load/store request; held until d_done
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data; valid while d_done=1, then held
- d_done  out  1  one-cycle completion pulse to data side
- mem_en  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; sampled when mem_ready=1
- mem_ready  in  1  memory completes the current access this cycle
- err  out  1  one-cycle pulse, coincident with done, when a transaction aborts on timeout

Behaviour:
- Reset: while reset=0 at a clock edge, the block enters IDLE and clears all of: mem_en, mem_we, mem_addr, mem_wdata, if_done, d_done, err, if_rdata, d_rdata, the timeout counter, and last_gnt (reset value 1 = data side, so fetch wins the first conflict). Reset mid-transaction abandons the access with no done pulse.
- States:
  - IDLE
    - Neither request: stay in IDLE.
    - Only if_req: go to BUSY_I.
    - Only d_req: go to BUSY_D.
    - Both requests: grant the side that was NOT last granted. Back-to-back contention therefore alternates I, D, I, D.
    - On grant: register the address (plus we and wdata for data) into the mem_* outputs, set mem_en=1, and update last_gnt.
    - A fetch access always has mem_we=0.
  - BUSY_I / BUSY_D
    - mem_en, mem_we, mem_addr and mem_wdata are held stable every cycle.
    - The counter increments each cycle that mem_ready=0.
    - mem_ready=1: register mem_rdata into the granted side's rdata (loads and fetches only; a store leaves d_rdata unchanged), pulse that side's done on the next cycle, drop mem_en, return to IDLE.
    - Counter reaches TIMEOUT with mem_ready=0: drop mem_en, pulse done and err together on the next cycle, force that side's rdata to 0, return to IDLE.
- Latency: request sampled high in cycle 0; mem_en high in cycle 1; mem_ready high in cycle 1 gives done in cycle 2. Each wait state adds one cycle.
- The return to IDLE costs one cycle. mem_en is low for at least one cycle between consecutive accesses.
- A requester dropping req while BUSY does not abort the access; it still completes and pulses done. A req still high in the done cycle starts a new arbitration in IDLE.
- mem_ready while in IDLE is ignored.
- The done pulses are mutually exclusive and never last more than one cycle.
- A store whose mem_ready and timeout coincide counts as success (ready wins).

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2) and the grant-side codes (GNT_I=1'b0, GNT_D=1'b1), alongside the existing control-FSM state defines.
- One natural sub-module: arb_timeout_cnt. It holds the clear/enable counter and compares against TIMEOUT.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Single fetch: if_req=1, if_addr=0x10, mem_ready=1 in the first busy cycle, mem_rdata=0xE3A01005 -> mem_en high exactly 1 cycle with mem_addr=0x10, mem_we=0; if_done pulses 2 cycles after the request with if_rdata=0xE3A01005; err=0.
- Store with wait states: d_req=1, d_we=1, d_addr=0x80, d_wdata=0xDEADBEEF, mem_ready held low 3 cycles -> mem_* stable for 4 cycles; d_done pulses once; d_rdata unchanged.
- Contention after reset: if_req and d_req both high continuously with zero-wait memory -> grant order I, D, I, D; one idle cycle between accesses; done pulses never overlap.
- Timeout: d_req load to 0x40, mem_ready stuck at 0, TIMEOUT=15 -> mem_en high exactly 15 cycles, then d_done=1 and err=1 in the same cycle, d_rdata=0.
- Reset mid-access: reset=0 during BUSY_D -> next cycle mem_en=0, state IDLE, no done or err pulse; first conflict after reset grants fetch.
- Early req drop: if_req deasserted one cycle after grant, mem_ready after 2 cycles -> if_done still pulses once with the captured data; no new access follows.
